regfile_mbox_arbiter: RTL and testbench

- Shares the PS-visible mailbox slots of the AXI register file between N_REQ fabric requesters.
- Round-robin arbitration picks one requester at a time and posts its 32-bit message to the mailbox read-back registers with an 8-bit sequence number.
- Waits for the PS to echo that sequence number through a control register before granting the next requester.
- Runs in the axi_aclk domain, between fabric clients and the regfile slv_reg/slv_read banks.

---
 rtl/regfile_mbox_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_mbox_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mbox_arbiter.sv
// Mailbox arbiter: shares one PS-visible mailbox between N_REQ fabric requesters.
// It grants requesters round-robin, posts the winner's message with an 8-bit
// sequence number, and holds off the next grant until the PS echoes that number
// back, the PS disables the block, or the optional ack timeout expires.
module regfile_mbox_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*32-1:0]  req_data,
  output logic [N_REQ-1:0]     gnt,
  input  logic [31:0]          host_ctrl,
  input  logic [31:0]          host_ack,
  output logic [31:0]          mbox_data,
  output logic [31:0]          mbox_status
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [31:0]        mbox_data_q, mbox_data_d;
  logic [7:0]         seq_q, seq_d;
  logic [3:0]         src_q, src_d;
  logic [3:0]         rr_last_q, rr_last_d;
  logic               pending_q, pending_d;
  logic               en_q, en_d;
  logic [15:0]        tc_q, tc_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic               enable, clear_to;
  logic               ack_hit, to_hit;
  logic               win_found, hi_found;
  logic [3:0]         win_idx, hi_idx, lo_idx;
  logic [31:0]        win_data;
  logic               unused_bits;

  assign enable      = host_ctrl[0];
  assign clear_to    = host_ctrl[1];
  assign unused_bits = ^{host_ctrl[31:2], host_ack[31:8]};
  assign ack_hit     = (host_ack[7:0] == seq_q);
  assign to_hit      = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LAST);

  // Saturating increment so the timeout counter sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin pick: lowest set req above rr_last, else lowest set req overall (wrap).
  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    win_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(rr_last_q)) begin
          hi_found = 1'b1;
          hi_idx   = 4'(i);
        end
        win_found = 1'b1;
        lo_idx    = 4'(i);
      end
    end
    win_idx  = hi_found ? hi_idx : lo_idx;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == 4'(i)) win_data = req_data[32*i +: 32];
    end
  end

  // FSM state register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // FSM next-state: leave WAIT_ACK on disable, matching ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable && win_found) state_d = WAIT_ACK;
      WAIT_ACK: if (!enable || ack_hit || to_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs and mailbox datapath updates.
  always_comb begin
    gnt_d       = '0;
    mbox_data_d = mbox_data_q;
    seq_d       = seq_q;
    src_d       = src_q;
    rr_last_d   = rr_last_q;
    pending_d   = pending_q;
    wait_cnt_d  = wait_cnt_q;
    tc_d        = tc_q;
    en_d        = enable;
    case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == 4'(i)) gnt_d[i] = 1'b1;
          end
          mbox_data_d = win_data;
          src_d       = win_idx;
          seq_d       = seq_q + 8'd1;
          pending_d   = 1'b1;
          wait_cnt_d  = '0;
        end
      end
      WAIT_ACK: begin
        // A disable abandons the post without advancing the rotation.
        if (!enable) begin
          pending_d = 1'b0;
        end else if (ack_hit) begin
          pending_d = 1'b0;
          rr_last_d = src_q;
        end else if (to_hit) begin
          pending_d = 1'b0;
          rr_last_d = src_q;
          tc_d      = sat_inc16(tc_q);
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (clear_to) tc_d = '0;
  end

  // Mailbox and arbitration registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      gnt_q       <= '0;
      mbox_data_q <= '0;
      seq_q       <= '0;
      src_q       <= '0;
      rr_last_q   <= 4'(N_REQ - 1);
      pending_q   <= 1'b0;
      wait_cnt_q  <= '0;
      tc_q        <= '0;
      en_q        <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      mbox_data_q <= mbox_data_d;
      seq_q       <= seq_d;
      src_q       <= src_d;
      rr_last_q   <= rr_last_d;
      pending_q   <= pending_d;
      wait_cnt_q  <= wait_cnt_d;
      tc_q        <= tc_d;
      en_q        <= en_d;
    end
  end

  assign gnt         = gnt_q;
  assign mbox_data   = mbox_data_q;
  assign mbox_status = {tc_q, 2'b00, en_q, pending_q, src_q, seq_q};

endmodule

// File: tb/tb_regfile_mbox_arbiter.sv
// Bench for regfile_mbox_arbiter: grants are checked by a scoreboard monitor,
// status/timing details by direct checks in the stimulus thread.
module tb_regfile_mbox_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [31:0]  host_ctrl;
  logic [31:0]  host_ack;
  logic [31:0]  mbox_data;
  logic [31:0]  mbox_status;

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] data;
    logic [31:0] status;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  seq_m = 8'd0;
  logic [15:0] tc_m  = 16'd0;

  regfile_mbox_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .host_ctrl   (host_ctrl),
    .host_ack    (host_ack),
    .mbox_data   (mbox_data),
    .mbox_status (mbox_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle with a grant must match the oldest expected post.
  always @(negedge clk) begin
    if (gnt !== 4'b0000) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL grant_unexpected: gnt=%b data=%h status=%h, required no grant",
                 gnt, mbox_data, mbox_status);
      end else begin
        mon_e = sb_q.pop_front();
        if ({gnt, mbox_data, mbox_status} !== mon_e) begin
          n_err++;
          $display("FAIL grant: got gnt=%b data=%h status=%h, required gnt=%b data=%h status=%h",
                   gnt, mbox_data, mbox_status, mon_e.g, mon_e.data, mon_e.status);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int w, input logic [31:0] d);
    exp_t x;
    seq_m    = seq_m + 8'd1;
    x.g      = 4'(1 << w);
    x.data   = d;
    x.status = {tc_m, 2'b00, 1'b1, 1'b1, 4'(w), seq_m};
    sb_q.push_back(x);
  endtask

  task automatic wait_gnt(input int w);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (gnt[w]) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL gnt_timeout: requester %0d saw gnt=%b for 40 cycles, required gnt[%0d]=1",
               w, gnt, w);
    end
  endtask

  task automatic ack_seq();
    host_ack = {24'h0, seq_m};
    step();
    chk("ack_pending", 32'(mbox_status[12]), 32'd0);
  endtask

  task automatic do_post(input int w, input logic [31:0] d);
    req_data[32*w +: 32] = d;
    req[w] = 1'b1;
    expect_grant(w, d);
    wait_gnt(w);
    req[w] = 1'b0;
    ack_seq();
  endtask

  initial begin
    int k;
    int order [5] = '{2, 3, 0, 1, 2};
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    host_ctrl = '0;
    host_ack  = '0;

    // Reset state
    #12;
    chk("rst_gnt",    32'(gnt), 32'd0);
    chk("rst_data",   mbox_data, 32'd0);
    chk("rst_status", mbox_status, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // First post from requester 0
    host_ctrl = 32'h1;
    req_data[31:0] = 32'hDEADBEEF;
    req = 4'b0001;
    expect_grant(0, 32'hDEADBEEF);
    wait_gnt(0);
    req = 4'b0000;
    chk("post0_status", mbox_status, 32'h0000_3001);
    chk("post0_data",   mbox_data,   32'hDEADBEEF);
    ack_seq();
    chk("data_held", mbox_data, 32'hDEADBEEF);

    // Requester 1 gets seq 2
    req_data[63:32] = 32'h1111_0001;
    req = 4'b0010;
    expect_grant(1, 32'h1111_0001);
    wait_gnt(1);
    req = 4'b0000;
    chk("post1_status", mbox_status, 32'h0000_3102);
    ack_seq();

    // All requesting: rotation continues from rr_last=1
    req_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      expect_grant(order[i], req_data[32*order[i] +: 32]);
      wait_gnt(order[i]);
      step();
      step();
      chk("rr_pending_hold", 32'(mbox_status[12]), 32'd1);
      ack_seq();
    end
    req = 4'b0000;

    // Ack timeout after 16 cycles
    req_data[31:0] = 32'hCAFEF00D;
    req = 4'b0001;
    expect_grant(0, 32'hCAFEF00D);
    wait_gnt(0);
    req = 4'b0000;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (!mbox_status[12]) begin
        k = c;
        break;
      end
    end
    chk("timeout_latency", k, 32'd16);
    tc_m = 16'd1;
    chk("timeout_count", 32'(mbox_status[31:16]), 32'(tc_m));
    host_ctrl = 32'h3;
    step();
    host_ctrl = 32'h1;
    tc_m = 16'd0;
    chk("timeout_clear", 32'(mbox_status[31:16]), 32'd0);

    // Sequence wrap with a stale ack left at 255
    for (int i = 0; seq_m != 8'd255; i++) begin
      do_post(0, 32'hA500_0000 | 32'(i));
    end
    chk("seq_at_255", 32'(mbox_status[7:0]), 32'd255);
    req_data[31:0] = 32'h5EC0_0000;
    req = 4'b0001;
    expect_grant(0, 32'h5EC0_0000);
    wait_gnt(0);
    req = 4'b0000;
    chk("seq_wrapped", 32'(mbox_status[7:0]), 32'd0);
    repeat (8) step();
    chk("stale_ack_pending", 32'(mbox_status[12]), 32'd1);
    ack_seq();

    // Disable during WAIT_ACK keeps rr_last, so requester 1 wins again
    req_data[63:32] = 32'h1111_0001;
    req_data[95:64] = 32'h2222_0002;
    req = 4'b0110;
    expect_grant(1, 32'h1111_0001);
    wait_gnt(1);
    host_ctrl = 32'h0;
    step();
    chk("disable_status", mbox_status, 32'h0000_0101);
    repeat (3) step();
    expect_grant(1, 32'h1111_0001);
    host_ctrl = 32'h1;
    wait_gnt(1);
    req = 4'b0010;
    chk("regrant_status", mbox_status, 32'h0000_3102);

    // Asynchronous reset mid-wait
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt",    32'(gnt), 32'd0);
    chk("arst_data",   mbox_data, 32'd0);
    chk("arst_status", mbox_status, 32'd0);
    repeat (2) step();
    chk("arst_hold_status", mbox_status, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
